// File: rtl/counter_adder_param.sv
// Registered add/sub/accumulate unit with a limit-bounded up/down counter.
// Optional macro COUNTER_ADDER_SATURATE_EN clamps ADD/ACCUM/SUB results on carry/borrow.
module counter_adder_param #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             wrap
);

    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_UP    = 3'b001,
        OP_HOLD  = 3'b010,
        OP_DOWN  = 3'b011,
        OP_LOAD  = 3'b100,
        OP_ACCUM = 3'b101,
        OP_SUB   = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    logic [XW-1:0]    a_x, b_x, d_x, step_x;
    logic [XW-1:0]    sum_ab, diff_ab, sum_acc, up_val, down_val;
    logic [WIDTH-1:0] dout_n;
    logic             carry_n, wrap_n;

    // All arithmetic is one bit wider so carry/borrow survive.
    assign a_x      = {1'b0, a};
    assign b_x      = {1'b0, b};
    assign d_x      = {1'b0, dout};
    assign step_x   = XW'(STEP);
    assign sum_ab   = a_x + b_x;
    assign diff_ab  = a_x - b_x;
    assign sum_acc  = d_x + a_x;
    assign up_val   = d_x + step_x;
    assign down_val = d_x - step_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            carry <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            dout  <= dout_n;
            carry <= carry_n;
            wrap  <= wrap_n;
        end
    end

    always_comb begin
        dout_n  = dout;
        carry_n = carry;
        wrap_n  = 1'b0;
        if (en) begin
            case (op_e'(select))
                OP_ADD: begin
                    carry_n = sum_ab[WIDTH];
`ifdef COUNTER_ADDER_SATURATE_EN
                    dout_n  = sum_ab[WIDTH] ? '1 : sum_ab[WIDTH-1:0];
`else
                    dout_n  = sum_ab[WIDTH-1:0];
`endif
                end
                OP_SUB: begin
                    carry_n = diff_ab[WIDTH];
`ifdef COUNTER_ADDER_SATURATE_EN
                    dout_n  = diff_ab[WIDTH] ? '0 : diff_ab[WIDTH-1:0];
`else
                    dout_n  = diff_ab[WIDTH-1:0];
`endif
                end
                OP_ACCUM: begin
                    carry_n = sum_acc[WIDTH];
`ifdef COUNTER_ADDER_SATURATE_EN
                    dout_n  = sum_acc[WIDTH] ? '1 : sum_acc[WIDTH-1:0];
`else
                    dout_n  = sum_acc[WIDTH-1:0];
`endif
                end
                // b is the inclusive upper limit; starting above it wraps at once.
                OP_UP: begin
                    if (up_val > b_x) begin
                        dout_n = '0;
                        wrap_n = 1'b1;
                    end else begin
                        dout_n = up_val[WIDTH-1:0];
                    end
                end
                // Borrow out of dout-STEP means dout < STEP: reload from b.
                OP_DOWN: begin
                    if (down_val[WIDTH]) begin
                        dout_n = b;
                        wrap_n = 1'b1;
                    end else begin
                        dout_n = down_val[WIDTH-1:0];
                    end
                end
                OP_LOAD:  dout_n = a;
                OP_CLEAR: begin
                    dout_n  = '0;
                    carry_n = 1'b0;
                end
                OP_HOLD: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_adder_param.sv
// Scoreboard bench for counter_adder_param: STEP=1 and STEP=2 instances at WIDTH=4.
module tb_counter_adder_param;

    typedef struct packed {
        logic [3:0] d;
        logic       c;
        logic       w;
    } exp_t;

`ifdef COUNTER_ADDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [2:0] ADD = 3'd0, UP = 3'd1, HOLD = 3'd2, DOWN = 3'd3,
                           LOAD = 3'd4, ACCUM = 3'd5, SUB = 3'd6, CLEAR = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en1 = 1'b0, en2 = 1'b0;
    logic [2:0] sel1 = HOLD, sel2 = HOLD;
    logic [3:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
    logic [3:0] dout1, dout2;
    logic       carry1, carry2, wrap1, wrap2;

    int checks = 0;
    int failures = 0;
    int n1 = 0, n2 = 0;
    exp_t q1[$];
    exp_t q2[$];

    counter_adder_param #(.WIDTH(4), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .select(sel1), .a(a1), .b(b1),
        .dout(dout1), .carry(carry1), .wrap(wrap1)
    );

    counter_adder_param #(.WIDTH(4), .STEP(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .select(sel2), .a(a2), .b(b2),
        .dout(dout2), .carry(carry2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    // Monitor: every edge presents a result; compare it against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            checks++;
            if ({dout1, carry1, wrap1} !== e) begin
                failures++;
                $display("FAIL dut1_vec%0d: got dout=%0d carry=%b wrap=%b, want dout=%0d carry=%b wrap=%b",
                         n1, dout1, carry1, wrap1, e.d, e.c, e.w);
            end
            n1++;
        end
        if (q2.size() > 0) begin
            exp_t e;
            e = q2.pop_front();
            checks++;
            if ({dout2, carry2, wrap2} !== e) begin
                failures++;
                $display("FAIL dut2_vec%0d: got dout=%0d carry=%b wrap=%b, want dout=%0d carry=%b wrap=%b",
                         n2, dout2, carry2, wrap2, e.d, e.c, e.w);
            end
            n2++;
        end
    end

    task automatic cyc1(input logic [2:0] s, input logic [3:0] av, input logic [3:0] bv,
                        input logic e, input logic [3:0] d, input logic c, input logic w);
        @(negedge clk);
        sel1 = s; a1 = av; b1 = bv; en1 = e; en2 = 1'b0;
        q1.push_back('{d: d, c: c, w: w});
    endtask

    task automatic cyc2(input logic [2:0] s, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] d, input logic c, input logic w);
        @(negedge clk);
        sel2 = s; a2 = av; b2 = bv; en2 = 1'b1; en1 = 1'b0;
        q2.push_back('{d: d, c: c, w: w});
    endtask

    task automatic check_now(input string name, input logic [3:0] d, input logic c, input logic w);
        checks++;
        if ({dout1, carry1, wrap1, dout2, carry2, wrap2} !== {d, c, w, d, c, w}) begin
            failures++;
            $display("FAIL %s: got dut1=%0d/%b/%b dut2=%0d/%b/%b, want %0d/%b/%b",
                     name, dout1, carry1, wrap1, dout2, carry2, wrap2, d, c, w);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_now("reset_initial", 4'd0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;

        // UP with limit 3 from 0
        cyc1(CLEAR, 0, 0, 1, 4'd0, 0, 0);
        cyc1(UP, 0, 3, 1, 4'd1, 0, 0);
        cyc1(UP, 0, 3, 1, 4'd2, 0, 0);
        cyc1(UP, 0, 3, 1, 4'd3, 0, 0);
        cyc1(UP, 0, 3, 1, 4'd0, 0, 1);
        cyc1(UP, 0, 3, 1, 4'd1, 0, 0);
        // DOWN with limit 5 from LOAD 2
        cyc1(LOAD, 2, 0, 1, 4'd2, 0, 0);
        cyc1(DOWN, 0, 5, 1, 4'd1, 0, 0);
        cyc1(DOWN, 0, 5, 1, 4'd0, 0, 0);
        cyc1(DOWN, 0, 5, 1, 4'd5, 0, 1);
        cyc1(DOWN, 0, 5, 1, 4'd4, 0, 0);
        // arithmetic, carry kept by LOAD
        cyc1(ADD, 9, 8, 1, SAT ? 4'd15 : 4'd1, 1, 0);
        cyc1(LOAD, 3, 0, 1, 4'd3, 1, 0);
        cyc1(SUB, 2, 3, 1, SAT ? 4'd0 : 4'd15, 1, 0);
        cyc1(SUB, 7, 2, 1, 4'd5, 0, 0);
        cyc1(CLEAR, 0, 0, 1, 4'd0, 0, 0);
        cyc1(ACCUM, 6, 0, 1, 4'd6, 0, 0);
        cyc1(ACCUM, 6, 0, 1, 4'd12, 0, 0);
        cyc1(ACCUM, 6, 0, 1, SAT ? 4'd15 : 4'd2, 1, 0);
        // enable low during UP at 2, then HOLD and CLEAR
        cyc1(LOAD, 1, 0, 1, 4'd1, 1, 0);
        cyc1(UP, 0, 9, 1, 4'd2, 1, 0);
        cyc1(UP, 0, 9, 0, 4'd2, 1, 0);
        cyc1(ADD, 7, 7, 0, 4'd2, 1, 0);
        cyc1(UP, 0, 9, 0, 4'd2, 1, 0);
        cyc1(UP, 0, 9, 1, 4'd3, 1, 0);
        cyc1(HOLD, 5, 5, 1, 4'd3, 1, 0);
        cyc1(CLEAR, 0, 0, 1, 4'd0, 0, 0);
        // b=0 wraps every cycle; en low kills wrap
        cyc1(UP, 0, 0, 1, 4'd0, 0, 1);
        cyc1(UP, 0, 0, 1, 4'd0, 0, 1);
        cyc1(UP, 0, 0, 0, 4'd0, 0, 0);
        // dout above limit on entry
        cyc1(LOAD, 9, 0, 1, 4'd9, 0, 0);
        cyc1(UP, 0, 4, 1, 4'd0, 0, 1);
        cyc1(LOAD, 9, 0, 1, 4'd9, 0, 0);
        cyc1(DOWN, 0, 4, 1, 4'd8, 0, 0);
        cyc1(DOWN, 0, 4, 1, 4'd7, 0, 0);
        // set carry, then count to 5 and reset asynchronously mid-UP
        cyc1(ADD, 15, 15, 1, SAT ? 4'd15 : 4'd14, 1, 0);
        cyc1(LOAD, 4, 0, 1, 4'd4, 1, 0);
        cyc1(UP, 0, 9, 1, 4'd5, 1, 0);
        @(negedge clk);
        sel1 = UP; b1 = 4'd9; en1 = 1'b1;
        #2 rst = 1'b1;
        #1 check_now("reset_async", 4'd0, 1'b0, 1'b0);
        @(negedge clk) check_now("reset_held", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        q1.push_back('{d: 4'd1, c: 1'b0, w: 1'b0});
        cyc1(UP, 0, 9, 1, 4'd2, 0, 0);

        // STEP=2 instance: DOWN from 3 with limit 5, then UP past the limit
        cyc2(LOAD, 3, 0, 4'd3, 0, 0);
        cyc2(DOWN, 0, 5, 4'd1, 0, 0);
        cyc2(DOWN, 0, 5, 4'd5, 0, 1);
        cyc2(UP, 0, 5, 4'd0, 0, 1);
        cyc2(UP, 0, 5, 4'd2, 0, 0);
        cyc2(UP, 0, 5, 4'd4, 0, 0);
        cyc2(UP, 0, 5, 4'd0, 0, 1);
        cyc2(ADD, 12, 3, 4'd15, 0, 0);

        @(negedge clk);
        en1 = 1'b0; en2 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (q1.size() + q2.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q1.size() + q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_adder_param.md
COUNTER_ADDER_PARAM -- requirements
Module: counter_adder_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data/count width in bits (legal 2..32).
REQ-002 SHALL have parameter STEP, default 1, count increment/decrement (1 <= STEP < 2**WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  operation enable; low = freeze all state.
REQ-006 SHALL have port select  input  3  mode select (encoding REQ-010).
REQ-007 SHALL have port a  input  WIDTH  operand A / load value.
REQ-008 SHALL have port b  input  WIDTH  operand B / count limit.
REQ-009 SHALL have ports dout  output  WIDTH  registered result; carry  output  1  registered carry/borrow; wrap  output  1  registered one-cycle terminal-count pulse.

Function
REQ-010 SHALL decode select as: 000 ADD, 001 UP, 010 HOLD, 011 DOWN, 100 LOAD, 101 ACCUM, 110 SUB, 111 CLEAR.
REQ-011 SHALL apply every operation at the rising clk edge following the one where select/a/b/en are sampled: latency 1 cycle, outputs registered, no combinational path from inputs to outputs.
REQ-012 SHALL, in ADD, set dout <= (a+b) mod 2**WIDTH and carry <= bit WIDTH of a+b.
REQ-013 SHALL, in SUB, set dout <= (a-b) mod 2**WIDTH and carry <= 1 iff a < b (borrow).
REQ-014 SHALL, in ACCUM, set dout <= (dout+a) mod 2**WIDTH and carry <= bit WIDTH of dout+a.
REQ-015 SHALL, in UP, set dout <= 0 and wrap <= 1 if dout+STEP > b, else dout <= dout+STEP, wrap <= 0 (b is inclusive upper limit; b = 0 gives dout held at 0 with wrap every cycle).
REQ-016 SHALL, in DOWN, set dout <= b and wrap <= 1 if dout < STEP, else dout <= dout-STEP, wrap <= 0.
REQ-017 SHALL, in UP/DOWN with dout > b on entry, treat UP as wrap (dout <= 0, wrap <= 1) and DOWN as normal decrement.
REQ-018 SHALL, in LOAD, set dout <= a; in CLEAR, set dout <= 0 and carry <= 0; in HOLD, keep dout and carry.
REQ-019 SHALL keep carry unchanged in UP, DOWN, LOAD and HOLD.
REQ-020 SHALL drive wrap <= 0 in every mode other than UP/DOWN and on any cycle with en = 0; wrap is never high two cycles unless the wrap condition recurs.
REQ-021 SHALL, with en = 0, hold dout and carry regardless of select.
REQ-022 SHALL compute all arithmetic at WIDTH+1 bits internally; intermediate results never truncated before carry extraction.
REQ-023 SHALL take mode changes effect on the very next edge with no idle or transition cycle; the current dout is the starting point of the new mode.

Reset
REQ-024 SHALL, while rst = 1, force dout = 0, carry = 0, wrap = 0 immediately, independent of clk.
REQ-025 SHALL, on rst deassertion, perform the first operation on the first rising clk edge with rst = 0; rst mid-count abandons the count with no pending wrap.

Configuration
REQ-026 SHALL support macro COUNTER_ADDER_SATURATE_EN.
REQ-027 SHALL, with COUNTER_ADDER_SATURATE_EN defined, clamp ADD/ACCUM results to all-ones and SUB results to 0 on carry/borrow, carry still set as in REQ-012..014.
REQ-028 SHALL, without COUNTER_ADDER_SATURATE_EN, wrap modulo 2**WIDTH as in REQ-012..014; UP/DOWN behaviour is identical in both builds.

Verification (WIDTH=4, STEP=1 unless stated)
REQ-029 SHALL cover reset: rst=1 mid-UP with dout=5 -> dout=0, carry=0, wrap=0 before next clk edge.
REQ-030 SHALL cover UP with b=3 from dout=0: dout 1,2,3,0,1; wrap=1 only on the cycle dout becomes 0.
REQ-031 SHALL cover DOWN with b=5 from LOAD a=2: dout 2,1,0,5,4; wrap=1 on the cycle dout becomes 5; STEP=2 run from 3 -> 1,5 with wrap.
REQ-032 SHALL cover ADD a=9,b=8 -> dout=1, carry=1 (saturate build: dout=15, carry=1); SUB a=2,b=3 -> dout=15, carry=1 (saturate build: dout=0).
REQ-033 SHALL cover ACCUM a=6 from dout=0 for 3 cycles -> 6,12,2 with carry=1 on third (saturate: 6,12,15).
REQ-034 SHALL cover en=0 for 3 cycles during UP at dout=2 -> dout stays 2, wrap=0; HOLD then CLEAR -> dout held then 0, carry 0.
